// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// controller FSM states and the result-source encoding of a load.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        TRAP     = 2'b10
    } ctrl_state_e;

    localparam logic [1:0] RES_LOAD = 2'b01;

endpackage

// File: rtl/fwd_unit.sv
// Forward select for one E-stage source operand. M has priority over W, and a
// destination of x0 is never forwarded because x0 always reads as zero.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output fwd_sel_e   fwd_sel_o
);

    always_comb begin
        fwd_sel_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
            fwd_sel_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
            fwd_sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stalls, flushes,
// forwarding and memory-timeout trap. PIPELINE_CTRL_PERF_EN adds perf counters.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  rs1_d_i,
    input  logic [4:0]  rs2_d_i,
    input  logic [4:0]  rs1_e_i,
    input  logic [4:0]  rs2_e_i,
    input  logic [4:0]  rd_e_i,
    input  logic [1:0]  result_src_e_i,
    input  logic        pc_src_e_i,
    input  logic [4:0]  rd_m_i,
    input  logic        reg_write_m_i,
    input  logic        mem_req_m_i,
    input  logic        mem_ready_i,
    input  logic [4:0]  rd_w_i,
    input  logic        reg_write_w_i,
    output logic        stall_f_o,
    output logic        stall_d_o,
    output logic        stall_e_o,
    output logic        stall_m_o,
    output logic        flush_d_o,
    output logic        flush_e_o,
    output logic        flush_w_o,
    output logic [1:0]  forward_a_e_o,
    output logic [1:0]  forward_b_e_o,
    output logic        mem_err_o
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_count_o
`endif
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc;
    fwd_sel_e         fwd_a, fwd_b;
    logic             lw_stall, mem_wait;

    fwd_unit u_fwd_a (
        .rs_e_i        (rs1_e_i),
        .rd_m_i        (rd_m_i),
        .reg_write_m_i (reg_write_m_i),
        .rd_w_i        (rd_w_i),
        .reg_write_w_i (reg_write_w_i),
        .fwd_sel_o     (fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs_e_i        (rs2_e_i),
        .rd_m_i        (rd_m_i),
        .reg_write_m_i (reg_write_m_i),
        .rd_w_i        (rd_w_i),
        .reg_write_w_i (reg_write_w_i),
        .fwd_sel_o     (fwd_b)
    );

    assign lw_stall = (result_src_e_i == RES_LOAD) && (rd_e_i != 5'd0) &&
                      ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
    assign mem_wait = mem_req_m_i && !mem_ready_i;
    assign wait_cnt_inc = wait_cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // The counter only advances while waiting, so it stops at MEM_TIMEOUT.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_wait) begin
                    wait_cnt_d = wait_cnt_inc;
                    state_d    = (wait_cnt_inc == TIMEOUT_CNT) ? TRAP : MEM_WAIT;
                end else begin
                    wait_cnt_d = '0;
                    state_d    = RUN;
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_f_o     = 1'b0;
        stall_d_o     = 1'b0;
        stall_e_o     = 1'b0;
        stall_m_o     = 1'b0;
        flush_d_o     = 1'b0;
        flush_e_o     = 1'b0;
        flush_w_o     = 1'b0;
        forward_a_e_o = FWD_RF;
        forward_b_e_o = FWD_RF;
        mem_err_o     = 1'b0;
        if (rst_ni) begin
            forward_a_e_o = fwd_a;
            forward_b_e_o = fwd_b;
            mem_err_o     = (state_q == TRAP);
            // A pending branch flush waits until the memory stall releases.
            if ((state_q == TRAP) || mem_wait) begin
                stall_f_o = 1'b1;
                stall_d_o = 1'b1;
                stall_e_o = 1'b1;
                stall_m_o = 1'b1;
                flush_w_o = 1'b1;
            end else begin
                stall_f_o = lw_stall;
                stall_d_o = lw_stall;
                flush_d_o = pc_src_e_i;
                flush_e_o = lw_stall || pc_src_e_i;
            end
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cycles_o <= 32'd0;
            flush_count_o  <= 32'd0;
        end else begin
            if (stall_f_o && (stall_cycles_o != 32'hFFFF_FFFF)) begin
                stall_cycles_o <= stall_cycles_o + 32'd1;
            end
            if (flush_d_o && (flush_count_o != 32'hFFFF_FFFF)) begin
                flush_count_o <= flush_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios then random traffic,
// checked every cycle against a behavioural model of the hazard rules.
module tb_pipeline_ctrl;

    localparam int TMO = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [4:0] rs1_d_i, rs2_d_i, rs1_e_i, rs2_e_i, rd_e_i, rd_m_i, rd_w_i;
    logic [1:0] result_src_e_i;
    logic       pc_src_e_i, reg_write_m_i, mem_req_m_i, mem_ready_i, reg_write_w_i;
    logic       stall_f_o, stall_d_o, stall_e_o, stall_m_o;
    logic       flush_d_o, flush_e_o, flush_w_o, mem_err_o;
    logic [1:0] forward_a_e_o, forward_b_e_o;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cycles_o, flush_count_o;
`endif

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit      m_trap;
    int      m_wait;
    longint  m_stall_cnt, m_flush_cnt;
    bit      e_stall_f, e_flush_d, e_mw;

    always #5 clk_i = ~clk_i;

    pipeline_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .rs1_d_i        (rs1_d_i),
        .rs2_d_i        (rs2_d_i),
        .rs1_e_i        (rs1_e_i),
        .rs2_e_i        (rs2_e_i),
        .rd_e_i         (rd_e_i),
        .result_src_e_i (result_src_e_i),
        .pc_src_e_i     (pc_src_e_i),
        .rd_m_i         (rd_m_i),
        .reg_write_m_i  (reg_write_m_i),
        .mem_req_m_i    (mem_req_m_i),
        .mem_ready_i    (mem_ready_i),
        .rd_w_i         (rd_w_i),
        .reg_write_w_i  (reg_write_w_i),
        .stall_f_o      (stall_f_o),
        .stall_d_o      (stall_d_o),
        .stall_e_o      (stall_e_o),
        .stall_m_o      (stall_m_o),
        .flush_d_o      (flush_d_o),
        .flush_e_o      (flush_e_o),
        .flush_w_o      (flush_w_o),
        .forward_a_e_o  (forward_a_e_o),
        .forward_b_e_o  (forward_b_e_o),
        .mem_err_o      (mem_err_o)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .stall_cycles_o (stall_cycles_o),
        .flush_count_o  (flush_count_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (reg_write_m_i && rd_m_i != 5'd0 && rd_m_i == rs) return 2'b10;
        if (reg_write_w_i && rd_w_i != 5'd0 && rd_w_i == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_trap = 1'b0;
        m_wait = 0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    task automatic set_rst(input bit v);
        rst_ni = v;
        if (!v) model_reset();
    endtask

    task automatic idle_inputs();
        rs1_d_i = 0; rs2_d_i = 0; rs1_e_i = 0; rs2_e_i = 0; rd_e_i = 0;
        rd_m_i = 0; rd_w_i = 0; result_src_e_i = 0; pc_src_e_i = 0;
        reg_write_m_i = 0; reg_write_w_i = 0; mem_req_m_i = 0; mem_ready_i = 0;
    endtask

    task automatic check_outputs();
        bit lw, hold;
        logic [3:0] st;
        logic fd, fe, fw, err;
        logic [1:0] fa, fb;
        lw   = (result_src_e_i == 2'b01) && (rd_e_i != 0) &&
               ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
        e_mw = mem_req_m_i && !mem_ready_i;
        hold = m_trap || e_mw;
        if (!rst_ni) begin
            st = 4'b0000; fd = 0; fe = 0; fw = 0; err = 0; fa = 2'b00; fb = 2'b00;
        end else begin
            fa = exp_fwd(rs1_e_i);
            fb = exp_fwd(rs2_e_i);
            err = m_trap;
            if (hold) begin
                st = 4'b1111; fd = 0; fe = 0; fw = 1;
            end else begin
                st = {lw, lw, 1'b0, 1'b0}; fd = pc_src_e_i; fe = lw | pc_src_e_i; fw = 0;
            end
        end
        e_stall_f = st[3];
        e_flush_d = fd;
        chk("stall_f", 32'(stall_f_o), 32'(st[3]));
        chk("stall_d", 32'(stall_d_o), 32'(st[2]));
        chk("stall_e", 32'(stall_e_o), 32'(st[1]));
        chk("stall_m", 32'(stall_m_o), 32'(st[0]));
        chk("flush_d", 32'(flush_d_o), 32'(fd));
        chk("flush_e", 32'(flush_e_o), 32'(fe));
        chk("flush_w", 32'(flush_w_o), 32'(fw));
        chk("forward_a", 32'(forward_a_e_o), 32'(fa));
        chk("forward_b", 32'(forward_b_e_o), 32'(fb));
        chk("mem_err", 32'(mem_err_o), 32'(err));
`ifdef PIPELINE_CTRL_PERF_EN
        chk("stall_cycles", stall_cycles_o, 32'(m_stall_cnt));
        chk("flush_count", flush_count_o, 32'(m_flush_cnt));
`endif
    endtask

    // One cycle: check mid-cycle, then advance the model across the clock edge.
    task automatic tick();
        @(negedge clk_i);
        check_outputs();
        @(posedge clk_i);
        if (!rst_ni) begin
            model_reset();
        end else begin
            if (!m_trap) begin
                if (e_mw) begin
                    m_wait++;
                    if (m_wait >= TMO) m_trap = 1'b1;
                end else begin
                    m_wait = 0;
                end
            end
            if (e_stall_f && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
            if (e_flush_d && m_flush_cnt < 64'hFFFF_FFFF) m_flush_cnt++;
        end
        #1;
    endtask

    initial begin
        idle_inputs();
        set_rst(1'b0);
        tick();
        tick();
        set_rst(1'b1);
        tick();

        // Load-use: load x5 in E, D reads x5
        result_src_e_i = 2'b01; rd_e_i = 5; rs1_d_i = 5;
        tick();
        result_src_e_i = 2'b00;
        tick();

        // Forwarding priority and x0
        reg_write_m_i = 1; rd_m_i = 3; reg_write_w_i = 1; rd_w_i = 3; rs1_e_i = 3; rs2_e_i = 0;
        tick();
        rd_m_i = 0; rd_w_i = 0;
        tick();
        rd_w_i = 7; rs2_e_i = 7;
        tick();

        // Taken branch, then with a concurrent load-use
        idle_inputs();
        pc_src_e_i = 1;
        tick();
        result_src_e_i = 2'b01; rd_e_i = 9; rs2_d_i = 9;
        tick();

        // Memory wait 3 cycles with a pending branch, released on ready
        idle_inputs();
        pc_src_e_i = 1; mem_req_m_i = 1; mem_ready_i = 0;
        repeat (3) tick();
        mem_ready_i = 1;
        tick();
        idle_inputs();
        tick();

        // Timeout into TRAP, then frozen until reset
        mem_req_m_i = 1; mem_ready_i = 0;
        repeat (TMO) tick();
        @(negedge clk_i);
        chk("trap_mem_err", 32'(mem_err_o), 32'd1);
        #1;
        tick();
        mem_req_m_i = 0;
        repeat (2) tick();
        set_rst(1'b0);
        #1;
        chk("rst_stall_f", 32'(stall_f_o), 32'd0);
        chk("rst_mem_err", 32'(mem_err_o), 32'd0);
        tick();
        set_rst(1'b1);
        tick();

        // Reset in the middle of a wait restarts the timeout count
        mem_req_m_i = 1; mem_ready_i = 0;
        repeat (2) tick();
        set_rst(1'b0);
        tick();
        set_rst(1'b1);
        repeat (TMO - 1) tick();
        @(negedge clk_i);
        chk("midwait_no_trap", 32'(mem_err_o), 32'd0);
        #1;
        mem_ready_i = 1;
        tick();

        // Performance counters: 7 stall cycles, 2 flushes
        idle_inputs();
        set_rst(1'b0);
        tick();
        set_rst(1'b1);
        result_src_e_i = 2'b01; rd_e_i = 4; rs1_d_i = 4;
        repeat (7) tick();
        idle_inputs();
        pc_src_e_i = 1;
        repeat (2) tick();
        pc_src_e_i = 0;
        tick();
`ifdef PIPELINE_CTRL_PERF_EN
        chk("perf_stalls", stall_cycles_o, 32'd7);
        chk("perf_flushes", flush_count_o, 32'd2);
`endif

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rs1_d_i = 5'($urandom_range(0, 3));
            rs2_d_i = 5'($urandom_range(0, 3));
            rs1_e_i = 5'($urandom_range(0, 3));
            rs2_e_i = 5'($urandom_range(0, 3));
            rd_e_i  = 5'($urandom_range(0, 3));
            rd_m_i  = 5'($urandom_range(0, 3));
            rd_w_i  = 5'($urandom_range(0, 3));
            result_src_e_i = 2'($urandom);
            pc_src_e_i     = 1'($urandom);
            reg_write_m_i  = 1'($urandom);
            reg_write_w_i  = 1'($urandom);
            mem_req_m_i    = 1'($urandom);
            mem_ready_i    = ($urandom_range(0, 3) == 0);
            set_rst(($urandom_range(0, 99) != 0));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
